// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and register-index types.
// Used by the operand-fetch stage and its scoreboard.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/cpu_scoreboard.sv
// Busy bits for x1..x31 with writeback-aware lookups.
// Set beats clear on the same index; x0 is never busy.
module cpu_scoreboard
  import cpu_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     set_en_i,
  input  reg_idx_t set_idx_i,
  input  logic     clr_en_i,
  input  reg_idx_t clr_idx_i,
  input  logic     fclr_en_i,
  input  reg_idx_t fclr_idx_i,
  input  reg_idx_t look_a_i,
  input  reg_idx_t look_b_i,
  input  reg_idx_t look_c_i,
  output logic     busy_a_o,
  output logic     busy_b_o,
  output logic     busy_c_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // A register being written back this cycle is already free.
  function automatic logic eff(input reg_idx_t s);
    return busy_q[s] && !(clr_en_i && clr_idx_i == s);
  endfunction

  assign busy_a_o = eff(look_a_i);
  assign busy_b_o = eff(look_b_i);
  assign busy_c_o = eff(look_c_i);

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i)
      busy_d[clr_idx_i] = 1'b0;
    if (fclr_en_i)
      busy_d[fclr_idx_i] = 1'b0;
    if (set_en_i)
      busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/cpu_operand_fetch.sv
// Operand fetch: regfile read, writeback bypass, hazard
// stall against the scoreboard and execute pipeline register.
module cpu_operand_fetch
  import cpu_pkg::*;
#(
  parameter int PAYLOAD_W   = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dec_valid,
  output logic                   o_dec_ready,
  input  logic [4:0]             i_dec_rs1,
  input  logic [4:0]             i_dec_rs2,
  input  logic [4:0]             i_dec_rd,
  input  logic                   i_dec_rd_en,
  input  logic [PAYLOAD_W-1:0]   i_dec_payload,
  output logic [4:0]             o_rf_read_idx_a,
  input  logic [31:0]            i_rf_read_data_a,
  output logic [4:0]             o_rf_read_idx_b,
  input  logic [31:0]            i_rf_read_data_b,
  input  logic                   i_wb_en,
  input  logic [4:0]             i_wb_idx,
  input  logic [31:0]            i_wb_data,
  output logic                   o_ex_valid,
  input  logic                   i_ex_ready,
  output logic [31:0]            o_ex_op_a,
  output logic [31:0]            o_ex_op_b,
  output logic [4:0]             o_ex_rd,
  output logic                   o_ex_rd_en,
  output logic [PAYLOAD_W-1:0]   o_ex_payload,
  input  logic                   i_flush,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic                   valid_q, valid_d;
  xlen_t                  op_a_q, op_a_d;
  xlen_t                  op_b_q, op_b_d;
  reg_idx_t               rd_q, rd_d;
  logic                   rd_en_q, rd_en_d;
  logic [PAYLOAD_W-1:0]   pay_q, pay_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic  be_a, be_b, be_rd;
  logic  hazard, accept;
  xlen_t op_a, op_b;

  function automatic xlen_t pick(input reg_idx_t s,
                                 input xlen_t rf);
    if (s == '0)
      return '0;
    else if (i_wb_en && i_wb_idx == s)
      return i_wb_data;
    else
      return rf;
  endfunction

  cpu_scoreboard u_sb (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .set_en_i   (accept && i_dec_rd_en),
    .set_idx_i  (i_dec_rd),
    .clr_en_i   (i_wb_en),
    .clr_idx_i  (i_wb_idx),
    .fclr_en_i  (i_flush && valid_q && rd_en_q),
    .fclr_idx_i (rd_q),
    .look_a_i   (i_dec_rs1),
    .look_b_i   (i_dec_rs2),
    .look_c_i   (i_dec_rd),
    .busy_a_o   (be_a),
    .busy_b_o   (be_b),
    .busy_c_o   (be_rd)
  );

  assign o_rf_read_idx_a = i_dec_rs1;
  assign o_rf_read_idx_b = i_dec_rs2;
  assign op_a = pick(i_dec_rs1, i_rf_read_data_a);
  assign op_b = pick(i_dec_rs2, i_rf_read_data_b);

  // WAW also stalls: only one writer per register in flight.
  assign hazard = be_a || be_b || (i_dec_rd_en && be_rd);
  assign o_dec_ready = !hazard && !i_flush &&
                       (!valid_q || i_ex_ready);
  assign accept = i_dec_valid && o_dec_ready;

  always_comb begin
    valid_d = valid_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_d    = rd_q;
    rd_en_d = rd_en_q;
    pay_d   = pay_q;
    stall_d = stall_q;
    if (accept) begin
      valid_d = 1'b1;
      op_a_d  = op_a;
      op_b_d  = op_b;
      rd_d    = i_dec_rd;
      rd_en_d = i_dec_rd_en;
      pay_d   = i_dec_payload;
    end else if (i_flush || i_ex_ready) begin
      valid_d = 1'b0;
    end
    if (i_dec_valid && hazard && !i_flush && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rd_q    <= '0;
      rd_en_q <= 1'b0;
      pay_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rd_q    <= rd_d;
      rd_en_q <= rd_en_d;
      pay_q   <= pay_d;
      stall_q <= stall_d;
    end
  end

  assign o_ex_valid   = valid_q;
  assign o_ex_op_a    = op_a_q;
  assign o_ex_op_b    = op_b_q;
  assign o_ex_rd      = rd_q;
  assign o_ex_rd_en   = rd_en_q;
  assign o_ex_payload = pay_q;
  assign o_stall_cnt  = stall_q;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed bench for cpu_operand_fetch with a per-cycle
// reference model of the scoreboard and execute register.
module tb_cpu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_en;
  logic [31:0] pay;
  logic [4:0]  idx_a, idx_b;
  logic [31:0] rf_a, rf_b;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  ex_rd;
  logic        ex_rd_en;
  logic [31:0] ex_pay;
  logic        flush;
  logic [31:0] stall;

  logic [31:0] rf_mem [32];

  int checks = 0;
  int errors = 0;

  // Bench-side model state
  bit          m_busy [32];
  logic        m_valid;
  logic [31:0] m_a, m_b, m_pay, m_stall;
  logic [4:0]  m_rd;
  logic        m_rden;

  always #5 clk = ~clk;

  assign rf_a = rf_mem[idx_a];
  assign rf_b = rf_mem[idx_b];

  cpu_operand_fetch dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_dec_valid      (dec_valid),
    .o_dec_ready      (dec_ready),
    .i_dec_rs1        (rs1),
    .i_dec_rs2        (rs2),
    .i_dec_rd         (rd),
    .i_dec_rd_en      (rd_en),
    .i_dec_payload    (pay),
    .o_rf_read_idx_a  (idx_a),
    .i_rf_read_data_a (rf_a),
    .o_rf_read_idx_b  (idx_b),
    .i_rf_read_data_b (rf_b),
    .i_wb_en          (wb_en),
    .i_wb_idx         (wb_idx),
    .i_wb_data        (wb_data),
    .o_ex_valid       (ex_valid),
    .i_ex_ready       (ex_ready),
    .o_ex_op_a        (op_a),
    .o_ex_op_b        (op_b),
    .o_ex_rd          (ex_rd),
    .o_ex_rd_en       (ex_rd_en),
    .o_ex_payload     (ex_pay),
    .i_flush          (flush),
    .o_stall_cnt      (stall)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit beff(input logic [4:0] s);
    if (s == 0) return 1'b0;
    if (wb_en && wb_idx == s) return 1'b0;
    return m_busy[s];
  endfunction

  function automatic logic [31:0] src(input logic [4:0] s);
    if (s == 0) return 32'h0;
    if (wb_en && wb_idx == s) return wb_data;
    return rf_mem[s];
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_valid = 0; m_a = 0; m_b = 0; m_pay = 0;
    m_rd = 0; m_rden = 0; m_stall = 0;
  endtask

  task automatic idle();
    dec_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_en = 0;
    pay = 0; wb_en = 0; wb_idx = 0; wb_data = 0;
    flush = 0; ex_ready = 1; rst = 0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic de,
                       input logic [31:0] p);
    dec_valid = 1; rs1 = a; rs2 = b; rd = d; rd_en = de; pay = p;
  endtask

  // One cycle: check combinational outputs, advance model,
  // clock, then check registered outputs.
  task automatic step(input string tag);
    logic hz, rdy, acc;
    #1;
    hz  = beff(rs1) || beff(rs2) || (rd_en && beff(rd));
    rdy = !hz && !flush && (!m_valid || ex_ready);
    check({tag, ".dec_ready"}, {31'b0, dec_ready}, {31'b0, rdy});
    check({tag, ".idx_a"}, {27'b0, idx_a}, {27'b0, rs1});
    check({tag, ".idx_b"}, {27'b0, idx_b}, {27'b0, rs2});
    acc = dec_valid && rdy;
    if (rst) begin
      model_reset();
    end else begin
      if (dec_valid && hz && !flush && m_stall != 32'hFFFF_FFFF)
        m_stall++;
      if (wb_en && wb_idx != 0) m_busy[wb_idx] = 1'b0;
      if (acc) begin
        m_a = src(rs1); m_b = src(rs2);
        m_rd = rd; m_rden = rd_en; m_pay = pay;
        m_valid = 1;
        if (rd_en && rd != 0) m_busy[rd] = 1'b1;
      end else if (flush) begin
        if (m_valid && m_rden && m_rd != 0) m_busy[m_rd] = 1'b0;
        m_valid = 0;
      end else if (ex_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    if (wb_en && wb_idx != 0) rf_mem[wb_idx] = wb_data;
    #1;
    check({tag, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, m_valid});
    check({tag, ".op_a"}, op_a, m_a);
    check({tag, ".op_b"}, op_b, m_b);
    check({tag, ".ex_rd"}, {27'b0, ex_rd}, {27'b0, m_rd});
    check({tag, ".ex_rd_en"}, {31'b0, ex_rd_en}, {31'b0, m_rden});
    check({tag, ".payload"}, ex_pay, m_pay);
    check({tag, ".stall_cnt"}, stall, m_stall);
  endtask

  initial begin
    foreach (rf_mem[i]) rf_mem[i] = 32'h1000 + i;
    rf_mem[5] = 32'h11;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    step("reset");
    check("reset.lit_valid", {31'b0, ex_valid}, 32'h0);
    check("reset.lit_stall", stall, 32'h0);
    idle();

    // 1: plain read with x0 source
    issue(5, 0, 1, 0, 32'hA1);
    step("t1");
    check("t1.lit_op_a", op_a, 32'h11);
    check("t1.lit_op_b", op_b, 32'h0);
    check("t1.lit_valid", {31'b0, ex_valid}, 32'h1);

    // 2: RAW stall then release by writeback bypass
    issue(0, 0, 7, 1, 32'h2);
    step("t2.prod");
    issue(7, 0, 0, 0, 32'h3);
    repeat (3) step("t2.stall");
    check("t2.lit_stall3", stall, 32'd3);
    wb_en = 1; wb_idx = 7; wb_data = 32'hABCD;
    step("t2.wb");
    check("t2.lit_op_a", op_a, 32'hABCD);
    check("t2.lit_payload", ex_pay, 32'h3);
    wb_en = 0;
    issue(7, 0, 0, 0, 32'h4);
    step("t2.free");
    check("t2.lit_op_a_rf", op_a, 32'hABCD);

    // 3: execute backpressure holds the entry
    issue(5, 7, 0, 0, 32'h5);
    step("t3.load");
    ex_ready = 0;
    issue(0, 0, 0, 0, 32'h6);
    repeat (3) step("t3.hold");
    check("t3.lit_held_payload", ex_pay, 32'h5);
    check("t3.lit_held_op_b", op_b, 32'hABCD);
    ex_ready = 1;
    step("t3.release");
    check("t3.lit_next_payload", ex_pay, 32'h6);

    // 4: flush drops a held writer and frees its rd
    issue(0, 0, 3, 1, 32'h7);
    step("t4.load");
    dec_valid = 0; ex_ready = 0;
    step("t4.held");
    flush = 1;
    step("t4.flush");
    check("t4.lit_valid", {31'b0, ex_valid}, 32'h0);
    flush = 0; ex_ready = 1;
    issue(3, 0, 0, 0, 32'h8);
    step("t4.after");
    check("t4.lit_valid2", {31'b0, ex_valid}, 32'h1);
    check("t4.lit_payload", ex_pay, 32'h8);

    // 5: set beats same-cycle clear; x0 dest leaves scoreboard
    issue(0, 0, 9, 1, 32'h9);
    step("t5.first");
    wb_en = 1; wb_idx = 9; wb_data = 32'h99;
    issue(0, 0, 9, 1, 32'hA);
    step("t5.setclr");
    check("t5.lit_payload", ex_pay, 32'hA);
    wb_en = 0;
    issue(9, 0, 0, 0, 32'hB);
    step("t5.busy9");
    check("t5.lit_drained", {31'b0, ex_valid}, 32'h0);
    wb_en = 1; wb_idx = 9; wb_data = 32'h123;
    step("t5.bypass");
    check("t5.lit_bypass", op_a, 32'h123);
    wb_en = 0;
    issue(0, 0, 0, 1, 32'hC);
    step("t5.x0dst");
    issue(0, 0, 0, 1, 32'hD);
    step("t5.x0again");
    check("t5.lit_x0_payload", ex_pay, 32'hD);

    // 6: reset in the middle of a stall
    issue(0, 0, 12, 1, 32'hE);
    step("t6.load");
    ex_ready = 0;
    issue(12, 0, 0, 0, 32'hF);
    repeat (2) step("t6.stall");
    rst = 1;
    step("t6.rst");
    check("t6.lit_valid", {31'b0, ex_valid}, 32'h0);
    check("t6.lit_stall", stall, 32'h0);
    check("t6.lit_payload", ex_pay, 32'h0);
    check("t6.lit_rd_en", {31'b0, ex_rd_en}, 32'h0);
    rst = 0; ex_ready = 1;
    issue(12, 0, 0, 0, 32'h10);
    step("t6.after");
    check("t6.lit_accept", {31'b0, ex_valid}, 32'h1);
    idle();
    step("end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
